regfile_mp_sb: RTL and testbench

// - Parametrised multi-port integer register file for the pipelined RV64 core; successor of the single-write, non-forwarding regfile.
// - Adds N read / M write ports, write-to-read bypass, synchronous clear, and a per-register busy scoreboard for load-use and multi-cycle hazards.
// - Sits between decode (reads, issue) and writeback (writes); the decode stall logic consumes rs_busy.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_mp_sb.sv | 83 ++++++++
 tb/tb_regfile_mp_sb.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned DefRegWidth  = 64;
  localparam int unsigned DefNumRegs   = 32;
  localparam int unsigned DefNumRports = 2;
  localparam int unsigned DefNumWports = 2;
  localparam int unsigned DefAw        = $clog2(DefNumRegs);

  typedef logic [DefAw-1:0]       reg_addr_t;
  typedef logic [DefRegWidth-1:0] reg_data_t;

  typedef reg_addr_t [DefNumRports-1:0] rport_addr_t;
  typedef reg_data_t [DefNumRports-1:0] rport_data_t;
  typedef reg_addr_t [DefNumWports-1:0] wport_addr_t;
  typedef reg_data_t [DefNumWports-1:0] wport_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins on collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS   = DefNumRegs,
  parameter int unsigned NUM_WPORTS = DefNumWports,
  localparam int unsigned AW        = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           iss_valid_i,
  input  logic [AW-1:0]                  iss_rd_i,
  input  logic [NUM_WPORTS-1:0]          we_i,
  input  logic [NUM_WPORTS-1:0][AW-1:0]  rd_i,
  output logic [NUM_REGS-1:0]            busy_o,
  output logic [AW:0]                    busy_cnt_o
);

  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic [AW:0]         cnt_d, cnt_q;

  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_WPORTS; i++) begin
      if (we_i[i] && (rd_i[i] != '0)) busy_d[rd_i[i]] = 1'b0;
    end
    // A new producer supersedes one retiring in the same cycle.
    if (iss_valid_i && (iss_rd_i != '0)) busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DefRegWidth,
  parameter int unsigned NUM_REGS   = DefNumRegs,
  parameter int unsigned NUM_RPORTS = DefNumRports,
  parameter int unsigned NUM_WPORTS = DefNumWports,
  localparam int unsigned AW        = $clog2(NUM_REGS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_RPORTS-1:0][AW-1:0]       rs,
  output logic [NUM_RPORTS-1:0][REG_WIDTH-1:0] rs_dout,
  output logic [NUM_RPORTS-1:0]               rs_busy,
  input  logic [NUM_WPORTS-1:0]               we,
  input  logic [NUM_WPORTS-1:0][AW-1:0]       rd,
  input  logic [NUM_WPORTS-1:0][REG_WIDTH-1:0] rd_din,
  input  logic                                iss_valid,
  input  logic [AW-1:0]                       iss_rd,
  output logic [AW:0]                         busy_cnt
);

  logic [REG_WIDTH-1:0] mem_d [NUM_REGS];
  logic [REG_WIDTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;

  regfile_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .NUM_WPORTS (NUM_WPORTS)
  ) u_scoreboard (
    .clk_i       (clk),
    .reset_i     (reset),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .we_i        (we),
    .rd_i        (rd),
    .busy_o      (busy),
    .busy_cnt_o  (busy_cnt)
  );

  // Ascending port order so the highest-index writer lands last.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < NUM_WPORTS; i++) begin
      if (we[i] && (rd[i] != '0)) mem_d[rd[i]] = rd_din[i];
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rs_dout = '0;
    rs_busy = '0;
    for (int unsigned p = 0; p < NUM_RPORTS; p++) begin
      logic hit;
      hit        = 1'b0;
      rs_dout[p] = mem_q[rs[p]];
      for (int unsigned i = 0; i < NUM_WPORTS; i++) begin
        if (we[i] && (rd[i] == rs[p])) begin
          hit        = 1'b1;
          rs_dout[p] = rd_din[i];
        end
      end
      if (rs[p] == '0) begin
        rs_dout[p] = '0;
        hit        = 1'b0;
      end
      rs_busy[p] = busy[rs[p]] && !hit && (rs[p] != '0);
    end
  end

  a_we_known: assert property (@(posedge clk) !$isunknown(we));
  a_iss_known: assert property (@(posedge clk) !$isunknown(iss_valid));

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: bypass, port priority, scoreboard and reset.
module tb_regfile_mp_sb;

  logic             clk;
  logic             reset;
  logic [1:0][4:0]  rs;
  logic [1:0][63:0] rs_dout;
  logic [1:0]       rs_busy;
  logic [1:0]       we;
  logic [1:0][4:0]  rd;
  logic [1:0][63:0] rd_din;
  logic             iss_valid;
  logic [4:0]       iss_rd;
  logic [5:0]       busy_cnt;

  int total;
  int bad;

  regfile_mp_sb dut (
    .clk       (clk),
    .reset     (reset),
    .rs        (rs),
    .rs_dout   (rs_dout),
    .rs_busy   (rs_busy),
    .we        (we),
    .rd        (rd),
    .rd_din    (rd_din),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = '0;
    rd        = '0;
    rd_din    = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    rs    = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rs[0] = 5'd1; rs[1] = 5'd2; #1;
    check("rst_dout0", rs_dout[0], 64'd0);
    check("rst_dout1", rs_dout[1], 64'd0);
    check("rst_busy", 64'(rs_busy), 64'd0);
    check("rst_cnt", 64'(busy_cnt), 64'd0);

    // Bypass on both ports, then array value
    we[0] = 1'b1; rd[0] = 5'd5; rd_din[0] = 64'hA;
    rs[0] = 5'd5; rs[1] = 5'd5; #1;
    check("byp5_p0", rs_dout[0], 64'hA);
    check("byp5_p1", rs_dout[1], 64'hA);
    tick(); idle(); #1;
    check("arr5", rs_dout[0], 64'hA);

    // Same-rd conflict: port 1 wins, bypass and array
    we = 2'b11; rd[0] = 5'd7; rd[1] = 5'd7;
    rd_din[0] = 64'h11; rd_din[1] = 64'h22;
    rs[0] = 5'd7; #1;
    check("byp7_prio", rs_dout[0], 64'h22);
    tick(); idle(); #1;
    check("arr7_prio", rs_dout[0], 64'h22);
    check("arr5_keep", rs_dout[1], 64'hA);

    // x0 is hardwired zero
    we[0] = 1'b1; rd[0] = 5'd0; rd_din[0] = 64'hFF; rs[0] = 5'd0; #1;
    check("x0_byp", rs_dout[0], 64'd0);
    tick(); idle(); #1;
    check("x0_arr", rs_dout[0], 64'd0);

    // Issue x3, then writeback with same-cycle read
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick(); idle(); rs[0] = 5'd3; #1;
    check("x3_busy", 64'(rs_busy[0]), 64'd1);
    check("x3_cnt1", 64'(busy_cnt), 64'd1);
    we[1] = 1'b1; rd[1] = 5'd3; rd_din[1] = 64'h5; #1;
    check("x3_wb_busy", 64'(rs_busy[0]), 64'd0);
    check("x3_wb_dout", rs_dout[0], 64'h5);
    tick(); idle(); #1;
    check("x3_cnt0", 64'(busy_cnt), 64'd0);
    check("x3_clear", 64'(rs_busy[0]), 64'd0);

    // Set and clear on same register: set wins, data updated
    iss_valid = 1'b1; iss_rd = 5'd4;
    we[0] = 1'b1; rd[0] = 5'd4; rd_din[0] = 64'h44;
    tick(); idle(); rs[0] = 5'd4; #1;
    check("x4_setwin", 64'(rs_busy[0]), 64'd1);
    check("x4_data", rs_dout[0], 64'h44);
    check("x4_cnt", 64'(busy_cnt), 64'd1);

    // Issue to x0 is ignored
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick(); idle(); rs[1] = 5'd0; #1;
    check("x0_iss_cnt", 64'(busy_cnt), 64'd1);
    check("x0_iss_busy", 64'(rs_busy[1]), 64'd0);

    // WAW on x4: stays busy, first later write clears
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick(); idle(); #1;
    check("x4_waw_busy", 64'(rs_busy[0]), 64'd1);
    check("x4_waw_cnt", 64'(busy_cnt), 64'd1);
    we[0] = 1'b1; rd[0] = 5'd4; rd_din[0] = 64'h45;
    tick(); idle(); #1;
    check("x4_waw_clr", 64'(rs_busy[0]), 64'd0);
    check("x4_waw_cnt0", 64'(busy_cnt), 64'd0);

    // Write to a non-busy register leaves it non-busy
    we[1] = 1'b1; rd[1] = 5'd6; rd_din[1] = 64'h66;
    tick(); idle(); rs[0] = 5'd6; #1;
    check("x6_nonbusy", 64'(rs_busy[0]), 64'd0);
    check("x6_data", rs_dout[0], 64'h66);

    // Fill the scoreboard
    for (int r = 1; r < 32; r++) begin
      iss_valid = 1'b1; iss_rd = 5'(r);
      tick();
    end
    idle(); rs[0] = 5'd5; rs[1] = 5'd31; #1;
    check("full_cnt", 64'(busy_cnt), 64'd31);
    check("full_busy5", 64'(rs_busy[0]), 64'd1);
    check("full_busy31", 64'(rs_busy[1]), 64'd1);

    // Reset mid-stream beats same-cycle write and issue
    reset = 1'b1;
    we[0] = 1'b1; rd[0] = 5'd9; rd_din[0] = 64'h99;
    iss_valid = 1'b1; iss_rd = 5'd2;
    tick(); reset = 1'b0; idle(); rs[0] = 5'd7; rs[1] = 5'd9; #1;
    check("mrst_cnt", 64'(busy_cnt), 64'd0);
    check("mrst_x7", rs_dout[0], 64'd0);
    check("mrst_x9", rs_dout[1], 64'd0);
    check("mrst_busy", 64'(rs_busy), 64'd0);

    // Normal operation after reset
    we[0] = 1'b1; rd[0] = 5'd9; rd_din[0] = 64'h123;
    tick(); idle(); #1;
    check("post_x9", rs_dout[1], 64'h123);
    check("post_cnt", 64'(busy_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
